// File: rtl/rr_merge4to1_pkg.sv
// Shared constants and state encoding for the four-source round-robin merge.
package rr_merge4to1_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Round-robin successor; the 2-bit add wraps 3 -> 0 on its own.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_merge4to1_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_pick4
    import rr_merge4to1_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest one is written last.
    always_comb begin
        cand       = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        gnt_onehot = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt_onehot = NUM_SRC'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/rr_merge4to1.sv
// Four-source to one-sink round-robin merge with burst locking and one registered output slot.
//
//   state  | meaning
//   IDLE   | free arbitration, search starts at ptr
//   LOCKED | burst in progress, only lock_idx may transfer
module rr_merge4to1
    import rr_merge4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         in_valid,
    input  logic [NUM_SRC*WIDTH-1:0]   in_data,
    input  logic [NUM_SRC-1:0]         in_last,
    output logic [NUM_SRC-1:0]         in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       out_last,
    input  logic                       out_ready
);

    state_t               state, state_nx;
    logic [SEL_W-1:0]     ptr, ptr_nx;
    logic [SEL_W-1:0]     lock_idx, lock_nx;

    logic                 can_acc;
    logic                 xfer;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   gnt_onehot;
    logic [SEL_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic [WIDTH-1:0]     gnt_data;
    logic                 gnt_last;

    assign can_acc = !out_valid || out_ready;

    // While locked, mask every request except the burst owner.
    assign req = (state == LOCKED) ? (in_valid & (NUM_SRC'(1) << lock_idx)) : in_valid;

    rr_pick4 u_pick (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign xfer     = gnt_any && can_acc;
    assign in_ready = xfer ? gnt_onehot : '0;
    assign gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];
    assign gnt_last = in_last[gnt_idx];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        lock_nx  = lock_idx;
        if (xfer) begin
            if (gnt_last) begin
                state_nx = IDLE;
                ptr_nx   = next_idx(gnt_idx);
            end else begin
                state_nx = LOCKED;
                lock_nx  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            lock_idx <= lock_nx;
        end
    end

    // A load in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            out_last  <= gnt_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_merge4to1.sv
// Scoreboard bench for rr_merge4to1: reference arbiter model feeds an expected-beat queue, monitor pops it.
module tb_rr_merge4to1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       in_valid = '0;
    logic [4*WIDTH-1:0] in_data = '0;
    logic [3:0]       in_last = '0;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_last;
    logic             out_ready = 1'b0;

    always #5 clk = ~clk;

    rr_merge4to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] sel_log[$];
    int         n_checks = 0;
    int         n_errors = 0;

    // Reference model: who the spec says gets the grant, and whether the output slot is full.
    int         m_ptr = 0;
    int         m_lock_idx = 0;
    bit         m_locked = 0;
    bit         m_full = 0;
    logic [7:0] src_data[4];
    int         seq[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] mk_data(input int s, input int n);
        logic [31:0] a;
        logic [31:0] b;
        a = s;
        b = n;
        return {a[1:0], b[5:0]};
    endfunction

    task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rst);
        int         g;
        bit         found;
        bit         can;
        logic [3:0] exp_rdy;
        beat_t      b;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = src_data[i];
        #1;
        found = 0;
        g     = 0;
        if (!rst) begin
            if (m_locked) begin
                if (v[m_lock_idx]) begin
                    found = 1;
                    g     = m_lock_idx;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && v[(m_ptr + k) % 4]) begin
                        found = 1;
                        g     = (m_ptr + k) % 4;
                    end
                end
            end
            can     = !m_full || r;
            found   = found && can;
            exp_rdy = found ? 4'(1 << g) : 4'b0000;
            chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            if (found) begin
                b.sel  = 2'(g);
                b.data = src_data[g];
                b.last = l[g];
                exp_q.push_back(b);
            end
        end else begin
            exp_q.delete();
        end
        @(posedge clk);
        if (rst) begin
            m_ptr      = 0;
            m_locked   = 0;
            m_lock_idx = 0;
            m_full     = 0;
        end else if (found) begin
            if (l[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % 4;
            end else begin
                m_locked   = 1;
                m_lock_idx = g;
            end
            seq[g]++;
            src_data[g] = mk_data(g, seq[g]);
            m_full = 1;
        end else if (r) begin
            m_full = 0;
        end
    endtask

    // Compare the logged out_sel sequence; entry i sits at bits [2i+1:2i] of expv.
    task automatic check_log(input string name, input int n, input logic [31:0] expv);
        chk({name, "_len"}, sel_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < sel_log.size()) chk(name, {30'd0, sel_log[i]}, {30'd0, expv[2*i +: 2]});
        end
    endtask

    // Monitor: a beat leaves the DUT whenever out_valid & out_ready hold before the edge.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got sel %0d data %0h, expected no beat", out_sel, out_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_sel", {30'd0, out_sel}, {30'd0, b.sel});
                    chk("out_data", {24'd0, out_data}, {24'd0, b.data});
                    chk("out_last", {31'd0, out_last}, {31'd0, b.last});
                    sel_log.push_back(out_sel);
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        for (int i = 0; i < 4; i++) begin
            seq[i]      = 0;
            src_data[i] = mk_data(i, 0);
        end
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Reset in the middle of a src2 burst
        cycle(4'b0001, 4'b0001, 1'b1, 1'b0);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        sel_log.delete();
        cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
        cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_log("t1_after_reset", 1, 32'h0);

        // All four valid, single-beat, full throughput
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        sel_log.delete();
        for (int i = 0; i < 8; i++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_log("t2_sel", 8, 32'h0000_E4E4);

        // src1 three-beat burst with src0 and src3 waiting
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0001, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        sel_log.delete();
        cycle(4'b1011, 4'b1001, 1'b1, 1'b0);
        cycle(4'b1011, 4'b1001, 1'b1, 1'b0);
        cycle(4'b1011, 4'b1011, 1'b1, 1'b0);
        cycle(4'b1011, 4'b1011, 1'b1, 1'b0);
        cycle(4'b1011, 4'b1011, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_log("t3_sel", 5, 32'h0000_00D5);

        // Stall with out_ready low, then drain and load in one cycle
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0001, 1'b0, 1'b0);
        cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
        #1;
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
            #1;
            chk("t4_stable", {24'd0, out_data}, {24'd0, held});
        end
        cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Lone src3 beat, then pointer wraps back to src0
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        sel_log.delete();
        src_data[3] = 8'hA5;
        cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
        #1;
        chk("t5_data", {24'd0, out_data}, 32'h0000_00A5);
        chk("t5_sel", {30'd0, out_sel}, 32'd3);
        cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check_log("t5_wrap", 2, 32'h0000_0003);

        // Random traffic
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
        for (int n = 0; n < 10000; n++) begin
            v = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(v, l, r, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
